// File: rtl/pattern_response_capture_pkg.sv
// Shared types and defaults for the exhaustive-pattern response capture block.
// The FSM encoding is kept as plain constants so that legacy tools can consume it.
package pattern_response_capture_pkg;

    typedef logic [1:0] state_t;

    localparam state_t StIdle    = 2'd0;
    localparam state_t StCapture = 2'd1;
    localparam state_t StCompare = 2'd2;
    localparam state_t StDone    = 2'd3;

    localparam int unsigned DEF_SIG_W = 16;
    localparam logic [15:0] DEF_POLY  = 16'h1021;

endpackage

// File: rtl/pattern_response_capture_misr.sv
// Single combinational MISR step: shift left, fold the MSB back through POLY, xor in data.
// Kept standalone so other capture blocks can share the same compaction step.
module pr_misr
    import pattern_response_capture_pkg::*;
#(
    parameter int unsigned      SIG_W = DEF_SIG_W,
    parameter logic [SIG_W-1:0] POLY  = SIG_W'(DEF_POLY)
) (
    input  logic [SIG_W-1:0] sig_in,
    input  logic [SIG_W-1:0] d_in,
    output logic [SIG_W-1:0] sig_out
);

    always_comb begin
        sig_out = {sig_in[SIG_W-2:0], 1'b0} ^ (sig_in[SIG_W-1] ? POLY : '0) ^ d_in;
    end

endmodule

// File: rtl/pattern_response_capture.sv
// Accepts ascending stimulus vectors with their responses, compacts them into a MISR
// signature and reports pass/fail against a golden signature once all 2^N_WIDTH are seen.
module pattern_response_capture
    import pattern_response_capture_pkg::*;
#(
    parameter int unsigned      N_WIDTH = 3,
    parameter int unsigned      R_WIDTH = 1,
    parameter int unsigned      SIG_W   = DEF_SIG_W,
    parameter logic [SIG_W-1:0] POLY    = SIG_W'(DEF_POLY),
    parameter logic [SIG_W-1:0] SEED    = '0
) (
    input  logic               CK,
    input  logic               reset,
    input  logic               start,
    input  logic               vec_valid,
    input  logic [N_WIDTH-1:0] vec_in,
    input  logic [R_WIDTH-1:0] resp_in,
    input  logic [SIG_W-1:0]   golden_sig,
    output logic               busy,
    output logic               done,
    output logic               pass,
    output logic               fail,
    output logic               seq_err,
    output logic [SIG_W-1:0]   signature,
    output logic [N_WIDTH:0]   vec_count
);

    if (N_WIDTH + R_WIDTH > SIG_W) begin : g_width_check
        $error("pattern_response_capture: N_WIDTH+R_WIDTH must not exceed SIG_W");
    end

    state_t             state_q, state_d;
    logic [SIG_W-1:0]   sig_q, sig_d;
    logic [N_WIDTH:0]   cnt_q, cnt_d;
    logic               pass_q, pass_d;
    logic               fail_q, fail_d;
    logic               seq_err_q, seq_err_d;

    logic [SIG_W-1:0]   misr_d;
    logic [SIG_W-1:0]   misr_next;
    logic               vec_match;
    logic               last_vec;

    // Vector in the MSBs, response in the LSBs, zero-extended to the MISR width.
    always_comb begin
        misr_d = '0;
        misr_d[N_WIDTH+R_WIDTH-1:0] = {vec_in, resp_in};
    end

    pr_misr #(
        .SIG_W (SIG_W),
        .POLY  (POLY)
    ) u_misr (
        .sig_in  (sig_q),
        .d_in    (misr_d),
        .sig_out (misr_next)
    );

    assign vec_match = (vec_in == cnt_q[N_WIDTH-1:0]);
    assign last_vec  = (cnt_q[N_WIDTH-1:0] == {N_WIDTH{1'b1}});

    always_comb begin
        state_d   = state_q;
        sig_d     = sig_q;
        cnt_d     = cnt_q;
        pass_d    = pass_q;
        fail_d    = fail_q;
        seq_err_d = seq_err_q;

        case (state_q)
            StIdle, StDone: begin
                if (start) begin
                    sig_d     = SEED;
                    cnt_d     = '0;
                    pass_d    = 1'b0;
                    fail_d    = 1'b0;
                    seq_err_d = 1'b0;
                    state_d   = StCapture;
                end
            end
            StCapture: begin
                if (vec_valid) begin
                    if (vec_match) begin
                        sig_d = misr_next;
                        cnt_d = cnt_q + {{N_WIDTH{1'b0}}, 1'b1};
                        if (last_vec) begin
                            state_d = StCompare;
                        end
                    end else begin
                        // cnt_q is left pointing at the offending position.
                        seq_err_d = 1'b1;
                        fail_d    = 1'b1;
                        state_d   = StDone;
                    end
                end
            end
            StCompare: begin
                pass_d  = (sig_q == golden_sig);
                fail_d  = (sig_q != golden_sig);
                state_d = StDone;
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge CK or posedge reset) begin
        if (reset) begin
            state_q   <= StIdle;
            sig_q     <= SEED;
            cnt_q     <= '0;
            pass_q    <= 1'b0;
            fail_q    <= 1'b0;
            seq_err_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            sig_q     <= sig_d;
            cnt_q     <= cnt_d;
            pass_q    <= pass_d;
            fail_q    <= fail_d;
            seq_err_q <= seq_err_d;
        end
    end

    assign busy      = (state_q == StCapture) || (state_q == StCompare);
    assign done      = (state_q == StDone);
    assign pass      = pass_q;
    assign fail      = fail_q;
    assign seq_err   = seq_err_q;
    assign signature = sig_q;
    assign vec_count = cnt_q;

endmodule

// File: tb/tb_pattern_response_capture.sv
// Directed and randomized bench for pattern_response_capture (N=3, R=1, 8-bit MISR, POLY 07).
module tb_pattern_response_capture;

    localparam logic [7:0] P_POLY = 8'h07;

    logic       CK = 1'b0;
    logic       reset = 1'b1;
    logic       start = 1'b0;
    logic       vec_valid = 1'b0;
    logic [2:0] vec_in = '0;
    logic [0:0] resp_in = '0;
    logic [7:0] golden_sig = '0;
    logic       busy, done, pass, fail, seq_err;
    logic [7:0] signature;
    logic [3:0] vec_count;

    int checks = 0;
    int errors = 0;

    // Reference model, tracked as run-level facts rather than FSM states.
    logic [7:0] m_sig;
    int         m_cnt;
    bit         m_run, m_cmp, m_done, m_pass, m_fail, m_seq;

    pattern_response_capture #(
        .N_WIDTH (3),
        .R_WIDTH (1),
        .SIG_W   (8),
        .POLY    (P_POLY),
        .SEED    (8'h00)
    ) dut (
        .CK         (CK),
        .reset      (reset),
        .start      (start),
        .vec_valid  (vec_valid),
        .vec_in     (vec_in),
        .resp_in    (resp_in),
        .golden_sig (golden_sig),
        .busy       (busy),
        .done       (done),
        .pass       (pass),
        .fail       (fail),
        .seq_err    (seq_err),
        .signature  (signature),
        .vec_count  (vec_count)
    );

    always #5 CK = ~CK;

    // Signature as polynomial arithmetic: multiply by x modulo the feedback, add data.
    function automatic logic [7:0] ref_step(input logic [7:0] s, input int d);
        int t;
        t = int'(s) * 2;
        if (t > 255) t = (t - 256) ^ int'(P_POLY);
        t = t ^ d;
        return t[7:0];
    endfunction

    function automatic logic [7:0] ref_run(input bit r[8]);
        logic [7:0] s;
        s = 8'h00;
        for (int v = 0; v < 8; v++) s = ref_step(s, v * 2 + int'(r[v]));
        return s;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic chk_all(input string tag);
        chk({tag, ".busy"}, 32'(busy), 32'(m_run || m_cmp));
        chk({tag, ".done"}, 32'(done), 32'(m_done));
        chk({tag, ".pass"}, 32'(pass), 32'(m_pass));
        chk({tag, ".fail"}, 32'(fail), 32'(m_fail));
        chk({tag, ".seq_err"}, 32'(seq_err), 32'(m_seq));
        chk({tag, ".sig"}, 32'(signature), 32'(m_sig));
        chk({tag, ".cnt"}, 32'(vec_count), 32'(m_cnt));
    endtask

    task automatic model_reset();
        m_sig = 8'h00; m_cnt = 0;
        m_run = 0; m_cmp = 0; m_done = 0; m_pass = 0; m_fail = 0; m_seq = 0;
    endtask

    // One clock: drive inputs, advance the model on the edge, check 1 ns later.
    task automatic tick(input string tag, input bit s, input bit v, input int vec, input bit r);
        start = s; vec_valid = v; vec_in = vec[2:0]; resp_in = r;
        @(posedge CK);
        if (s && !(m_run || m_cmp)) begin
            m_sig = 8'h00; m_cnt = 0;
            m_pass = 0; m_fail = 0; m_seq = 0; m_done = 0; m_run = 1; m_cmp = 0;
        end else if (m_cmp) begin
            m_pass = (m_sig == golden_sig); m_fail = !m_pass; m_done = 1; m_cmp = 0;
        end else if (m_run && v) begin
            if (vec == m_cnt % 8) begin
                m_sig = ref_step(m_sig, vec * 2 + int'(r));
                m_cnt++;
                if (m_cnt == 8) begin m_run = 0; m_cmp = 1; end
            end else begin
                m_seq = 1; m_fail = 1; m_done = 1; m_run = 0;
            end
        end
        #1;
        start = 0; vec_valid = 0;
        chk_all(tag);
    endtask

    task automatic idle(input string tag);
        tick(tag, 0, 0, 0, 0);
    endtask

    logic [7:0] seq_tab [8] = '{8'h00, 8'h02, 8'h00, 8'h06, 8'h04, 8'h02, 8'h08, 8'h1E};

    initial begin
        bit resp_a [8];
        int bad_pos;
        model_reset();
        #12;
        chk_all("reset");
        reset = 1'b0;
        @(negedge CK);

        // Full ascending run, all responses 0.
        golden_sig = 8'h1E;
        tick("s1.start", 1, 0, 0, 0);
        for (int v = 0; v < 8; v++) begin
            tick("s1.vec", 0, 1, v, 0);
            chk("s1.tab", 32'(signature), 32'(seq_tab[v]));
        end
        chk("s1.done_early", 32'(done), 32'd0);
        idle("s1.cmp");
        chk("s1.done", 32'(done), 32'd1);
        chk("s1.pass", 32'(pass), 32'd1);
        chk("s1.cnt8", 32'(vec_count), 32'd8);

        // vec_valid in DONE without start has no effect.
        tick("s1.hold", 0, 1, 0, 1);
        tick("s1.hold", 0, 1, 3, 0);

        // Response flipped on the last vector.
        tick("s2.start", 1, 0, 0, 0);
        chk("s2.seed", 32'(signature), 32'h00);
        for (int v = 0; v < 8; v++) tick("s2.vec", 0, 1, v, v == 7);
        idle("s2.cmp");
        chk("s2.sig", 32'(signature), 32'h1F);
        chk("s2.fail", 32'(fail), 32'd1);

        // Out-of-order vector.
        tick("s3.start", 1, 0, 0, 0);
        tick("s3.v0", 0, 1, 0, 0);
        tick("s3.v1", 0, 1, 1, 0);
        tick("s3.v3", 0, 1, 3, 0);
        chk("s3.seq", 32'(seq_err), 32'd1);
        chk("s3.sig", 32'(signature), 32'h02);
        chk("s3.cnt", 32'(vec_count), 32'd2);

        // Gaps and a start pulse mid-run.
        tick("s4.start", 1, 0, 0, 0);
        for (int v = 0; v < 8; v++) begin
            tick("s4.vec", 0, 1, v, 0);
            idle("s4.gap");
            if (v == 3) tick("s4.midstart", 1, 0, 0, 0);
        end
        idle("s4.cmp");
        chk("s4.sig", 32'(signature), 32'h1E);
        chk("s4.pass", 32'(pass), 32'd1);

        // Asynchronous reset while vector 4 is presented.
        tick("s5.start", 1, 0, 0, 0);
        for (int v = 0; v < 4; v++) tick("s5.vec", 0, 1, v, 0);
        vec_valid = 1; vec_in = 3'd4;
        #3 reset = 1'b1;
        #1;
        model_reset();
        chk_all("s5.async");
        #2 reset = 1'b0; vec_valid = 0;
        tick("s5.restart", 1, 0, 0, 0);
        for (int v = 0; v < 8; v++) tick("s5.vec2", 0, 1, v, 0);
        idle("s5.cmp");
        chk("s5.sig", 32'(signature), 32'h1E);
        chk("s5.pass", 32'(pass), 32'd1);

        // Randomized runs: random responses, gaps, goldens and occasional bad ordering.
        for (int run = 0; run < 24; run++) begin
            for (int v = 0; v < 8; v++) resp_a[v] = bit'($urandom_range(0, 1));
            golden_sig = $urandom_range(0, 1) ? ref_run(resp_a) : 8'($urandom);
            bad_pos = (run % 4 == 3) ? int'($urandom_range(0, 7)) : 8;
            tick("rnd.start", 1, 0, 0, 0);
            for (int v = 0; v < 8; v++) begin
                while ($urandom_range(0, 3) == 0) tick("rnd.gap", bit'($urandom_range(0, 1)), 0, 0, 0);
                if (v == bad_pos) begin
                    tick("rnd.bad", 0, 1, (v + int'($urandom_range(1, 7))) % 8, resp_a[v]);
                    break;
                end
                tick("rnd.vec", 0, 1, v, resp_a[v]);
            end
            idle("rnd.end");
            if (bad_pos == 8) chk("rnd.fullsig", 32'(signature), 32'(ref_run(resp_a)));
            chk("rnd.excl", 32'(pass && fail), 32'd0);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL timeout: observed running expected finished");
        $fatal(1, "timeout");
    end

endmodule
